// File: rtl/rtc_bus_responder.sv
// Multiplexed address/data bus responder for a BCD real-time calendar clock.
// Optional countdown timer (0x41-0x43, control run/expired, alarma) is built only with `define RTC_TIMER_EN.
module rtc_bus_responder #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       a_d,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       alarma
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_inc = (v[3:0] >= 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic is_leap);
    case (m)
      8'h02:                      days_in_month = is_leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
      default:                    days_in_month = 8'h31;
    endcase
  endfunction

  // Two-deep sample pipeline: s1 is the newest sample, s2 the previous one.
  logic          cs_s1_reg, a_d_s1_reg, wr_s1_reg, rd_s1_reg;
  logic          cs_s2_reg, a_d_s2_reg, wr_s2_reg, rd_s2_reg;
  logic [7:0]    ad_s1_reg, ad_s2_reg;
  logic [7:0]    addr_reg, wr_data_reg;
  logic          wr_pend_reg;
  logic [PW-1:0] presc_reg;
  logic          tick_defer_reg;
  logic [7:0]    seg_reg, min_reg, hora_reg, dia_reg, mes_reg, anio_reg;
  logic [7:0]    seg_next, min_next, hora_next, dia_next, mes_next, anio_next;
  logic [7:0]    ad_out_reg;
  logic          ad_oe_reg;
  logic [7:0]    rd_mux;
  logic [7:0]    ctrl_val;
  logic [7:0]    dim;
  logic          leap_year;
  logic          c_min, c_hora, c_dia, c_mes, c_anio;
  logic          wr_rise, bus_ok, addr_strobe, data_strobe, read_cond;
  logic          tick_raw, tick_due, tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1_reg  <= 1'b1;
      a_d_s1_reg <= 1'b0;
      wr_s1_reg  <= 1'b1;
      rd_s1_reg  <= 1'b1;
      ad_s1_reg  <= 8'h00;
      cs_s2_reg  <= 1'b1;
      a_d_s2_reg <= 1'b0;
      wr_s2_reg  <= 1'b1;
      rd_s2_reg  <= 1'b1;
      ad_s2_reg  <= 8'h00;
    end else begin
      cs_s1_reg  <= cs;
      a_d_s1_reg <= a_d;
      wr_s1_reg  <= wr;
      rd_s1_reg  <= rd;
      ad_s1_reg  <= ad_in;
      cs_s2_reg  <= cs_s1_reg;
      a_d_s2_reg <= a_d_s1_reg;
      wr_s2_reg  <= wr_s1_reg;
      rd_s2_reg  <= rd_s1_reg;
      ad_s2_reg  <= ad_s1_reg;
    end
  end

  // A write strobe only counts if rd was idle in the low sample; rd+wr both low is a protocol error.
  assign wr_rise     = wr_s1_reg & ~wr_s2_reg;
  assign bus_ok      = ~cs_s2_reg & rd_s2_reg;
  assign addr_strobe = wr_rise & bus_ok & ~a_d_s2_reg;
  assign data_strobe = wr_rise & bus_ok & a_d_s2_reg;
  assign read_cond   = ~cs_s1_reg & a_d_s1_reg & ~rd_s1_reg & wr_s1_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg    <= 8'h00;
      wr_data_reg <= 8'h00;
      wr_pend_reg <= 1'b0;
    end else begin
      wr_pend_reg <= data_strobe;
      if (addr_strobe) addr_reg <= ad_s2_reg;
      if (data_strobe) wr_data_reg <= ad_s2_reg;
    end
  end

  assign tick_raw = (presc_reg == PW'(TICK_DIV - 1));
  assign tick_due = tick_raw | tick_defer_reg;
  assign tick     = tick_due & ~wr_pend_reg;

  // A tick colliding with a register commit is postponed one cycle; the prescaler keeps running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg      <= '0;
      tick_defer_reg <= 1'b0;
    end else begin
      presc_reg      <= tick_raw ? '0 : presc_reg + PW'(1);
      tick_defer_reg <= tick_due & wr_pend_reg;
    end
  end

  // BCD year divisible by 4: even tens need units 0/4/8, odd tens need units 2/6.
  assign leap_year = (anio_reg[1:0] == {anio_reg[4], 1'b0});

  always_comb begin
    dim       = days_in_month(mes_reg, leap_year);
    c_min     = (seg_reg >= 8'h59);
    c_hora    = c_min & (min_reg >= 8'h59);
    c_dia     = c_hora & (hora_reg >= 8'h23);
    c_mes     = c_dia & (dia_reg >= dim);
    c_anio    = c_mes & (mes_reg >= 8'h12);
    seg_next  = c_min ? 8'h00 : bcd_inc(seg_reg);
    min_next  = !c_min ? min_reg : (c_hora ? 8'h00 : bcd_inc(min_reg));
    hora_next = !c_hora ? hora_reg : (c_dia ? 8'h00 : bcd_inc(hora_reg));
    dia_next  = !c_dia ? dia_reg : (c_mes ? 8'h01 : bcd_inc(dia_reg));
    mes_next  = !c_mes ? mes_reg : (c_anio ? 8'h01 : bcd_inc(mes_reg));
    anio_next = !c_anio ? anio_reg : ((anio_reg >= 8'h99) ? 8'h00 : bcd_inc(anio_reg));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_reg  <= 8'h00;
      min_reg  <= 8'h00;
      hora_reg <= 8'h00;
      dia_reg  <= 8'h01;
      mes_reg  <= 8'h01;
      anio_reg <= 8'h00;
    end else if (wr_pend_reg) begin
      case (addr_reg)
        8'h21:   seg_reg  <= wr_data_reg;
        8'h22:   min_reg  <= wr_data_reg;
        8'h23:   hora_reg <= wr_data_reg;
        8'h24:   dia_reg  <= wr_data_reg;
        8'h25:   mes_reg  <= wr_data_reg;
        8'h26:   anio_reg <= wr_data_reg;
        default: ;
      endcase
    end else if (tick) begin
      seg_reg  <= seg_next;
      min_reg  <= min_next;
      hora_reg <= hora_next;
      dia_reg  <= dia_next;
      mes_reg  <= mes_next;
      anio_reg <= anio_next;
    end
  end

`ifdef RTC_TIMER_EN
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    bcd_dec = (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction

  logic [7:0] seg_t_reg, min_t_reg, hora_t_reg;
  logic [7:0] seg_t_next, min_t_next, hora_t_next;
  logic       run_reg, expired_reg;
  logic       b_min, b_hora, timer_zero;

  always_comb begin
    timer_zero  = ((seg_t_reg | min_t_reg | hora_t_reg) == 8'h00);
    b_min       = (seg_t_reg == 8'h00);
    b_hora      = b_min & (min_t_reg == 8'h00);
    seg_t_next  = b_min ? 8'h59 : bcd_dec(seg_t_reg);
    min_t_next  = !b_min ? min_t_reg : ((min_t_reg == 8'h00) ? 8'h59 : bcd_dec(min_t_reg));
    hora_t_next = !b_hora ? hora_t_reg : ((hora_t_reg == 8'h00) ? 8'h23 : bcd_dec(hora_t_reg));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_t_reg   <= 8'h00;
      min_t_reg   <= 8'h00;
      hora_t_reg  <= 8'h00;
      run_reg     <= 1'b0;
      expired_reg <= 1'b0;
    end else if (wr_pend_reg) begin
      case (addr_reg)
        8'h00: begin
          expired_reg <= 1'b0;
          run_reg     <= wr_data_reg[3];
        end
        8'h41:   seg_t_reg  <= wr_data_reg;
        8'h42:   min_t_reg  <= wr_data_reg;
        8'h43:   hora_t_reg <= wr_data_reg;
        default: ;
      endcase
    end else if (tick && run_reg) begin
      if (timer_zero) begin
        expired_reg <= 1'b1;
        run_reg     <= 1'b0;
      end else begin
        seg_t_reg  <= seg_t_next;
        min_t_reg  <= min_t_next;
        hora_t_reg <= hora_t_next;
      end
    end
  end

  assign ctrl_val = {4'b0000, run_reg, 2'b00, expired_reg};
  assign alarma   = ~expired_reg;
`else
  assign ctrl_val = 8'h00;
  assign alarma   = 1'b1;
`endif

  always_comb begin
    rd_mux = 8'h00;
    case (addr_reg)
      8'h00: rd_mux = ctrl_val;
      8'h21: rd_mux = seg_reg;
      8'h22: rd_mux = min_reg;
      8'h23: rd_mux = hora_reg;
      8'h24: rd_mux = dia_reg;
      8'h25: rd_mux = mes_reg;
      8'h26: rd_mux = anio_reg;
`ifdef RTC_TIMER_EN
      8'h41: rd_mux = seg_t_reg;
      8'h42: rd_mux = min_t_reg;
      8'h43: rd_mux = hora_t_reg;
`endif
      default: rd_mux = 8'h00;
    endcase
  end

  // Snapshot once at the start of a read so ad_out stays stable for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_out_reg <= 8'h00;
      ad_oe_reg  <= 1'b0;
    end else if (!read_cond) begin
      ad_oe_reg <= 1'b0;
    end else if (!ad_oe_reg) begin
      ad_oe_reg  <= 1'b1;
      ad_out_reg <= rd_mux;
    end
  end

  assign ad_out = ad_out_reg;
  assign ad_oe  = ad_oe_reg;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Scoreboard bench for rtc_bus_responder: reads push expected bytes, a monitor checks each ad_oe assertion.
// Bus activity is aligned to the known prescaler phase so ticks land only where intended.
module tb_rtc_bus_responder;
  localparam int TD = 64;

  logic       clk = 1'b0;
  logic       reset, cs, a_d, wr, rd;
  logic [7:0] ad_in, ad_out;
  logic       ad_oe, alarma;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc;
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       oe_prev = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_responder #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .cs(cs), .a_d(a_d), .wr(wr), .rd(rd),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .alarma(alarma)
  );

  // Mirrors the prescaler phase: a tick is applied on the edge that makes cyc a multiple of TD.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    string      nm;
    if (ad_oe && !oe_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: ad_out 0x%02h with no expectation queued", ad_out);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        $display("read  %s ad_out=0x%02h expected=0x%02h", nm, ad_out, e);
        check(nm, ad_out, e);
      end
    end
    oe_prev = ad_oe;
  end

  task automatic idle();
    cs = 1'b1; a_d = 1'b0; wr = 1'b1; rd = 1'b1;
  endtask

  // All bus tasks enter and leave on a falling edge.
  task automatic phase_write(input logic ph, input logic [7:0] v);
    cs = 1'b0; a_d = ph; ad_in = v; wr = 1'b0; rd = 1'b1;
    @(negedge clk);
    wr = 1'b1;
    @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] v);
    $display("write addr=0x%02h data=0x%02h", a, v);
    phase_write(1'b0, a);
    phase_write(1'b1, v);
  endtask

  task automatic read_reg(input logic [7:0] a, input logic [7:0] e, input string nm);
    phase_write(1'b0, a);
    exp_q.push_back(e);
    name_q.push_back(nm);
    cs = 1'b0; a_d = 1'b1; rd = 1'b0; wr = 1'b1;
    repeat (3) @(negedge clk);
    check({nm, "_oe_hold"}, ad_oe, 1);
    cs = 1'b1; rd = 1'b1;
    repeat (2) @(negedge clk);
    check({nm, "_oe_release"}, ad_oe, 0);
  endtask

  task automatic wait_phase(input int k);
    int guard;
    guard = 0;
    while ((cyc % TD) != k) begin
      @(negedge clk);
      guard++;
      if (guard > 4 * TD) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_phase: phase %0d not reached, cyc=%0d", k, cyc);
        break;
      end
    end
  endtask

  task automatic set_cal(input logic [7:0] y, input logic [7:0] m, input logic [7:0] d,
                         input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    wait_phase(1);
    write_reg(8'h26, y);
    write_reg(8'h25, m);
    write_reg(8'h24, d);
    write_reg(8'h23, h);
    write_reg(8'h22, mi);
    write_reg(8'h21, s);
  endtask

  task automatic check_cal(input string tag, input logic [7:0] y, input logic [7:0] m,
                           input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                           input logic [7:0] s);
    read_reg(8'h21, s,  {tag, "_seg"});
    read_reg(8'h22, mi, {tag, "_min"});
    read_reg(8'h23, h,  {tag, "_hora"});
    read_reg(8'h24, d,  {tag, "_dia"});
    read_reg(8'h25, m,  {tag, "_mes"});
    read_reg(8'h26, y,  {tag, "_anio"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ad_in = 8'h00;
    idle();
    repeat (3) @(negedge clk);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_alarma", alarma, 1);
    reset = 1'b0;

    // Reset contents, read before the first tick.
    check_cal("rst", 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

    // Basic write then read back, plus unmapped addresses.
    wait_phase(1);
    write_reg(8'h21, 8'h45);
    read_reg(8'h21, 8'h45, "rw_seg");
    write_reg(8'h30, 8'hAA);
    read_reg(8'h30, 8'h00, "unmapped_30");
    read_reg(8'h27, 8'h00, "unmapped_27");

    // Calendar rollovers, each across exactly one tick.
    set_cal(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    wait_phase(1);
    check_cal("feb_23", 8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
    set_cal(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    wait_phase(1);
    check_cal("feb_24", 8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
    set_cal(8'h07, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59);
    wait_phase(1);
    check_cal("apr_30", 8'h07, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00);
    set_cal(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    wait_phase(1);
    check_cal("dec_99", 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    set_cal(8'h23, 8'h02, 8'h28, 8'h10, 8'h10, 8'h5A);
    wait_phase(1);
    check_cal("nonbcd", 8'h23, 8'h02, 8'h28, 8'h10, 8'h11, 8'h00);

    // Data commit on the tick edge: write lands, tick follows one cycle later.
    wait_phase(1);
    write_reg(8'h22, 8'h30);
    write_reg(8'h21, 8'h10);
    phase_write(1'b0, 8'h21);
    wait_phase(TD - 4);
    $display("write addr=0x21 data=0x33 (on tick edge)");
    phase_write(1'b1, 8'h33);
    read_reg(8'h21, 8'h34, "tickcol_seg");
    read_reg(8'h22, 8'h30, "tickcol_min");

    // rd and wr low together: no read, no write.
    wait_phase(1);
    write_reg(8'h22, 8'h12);
    phase_write(1'b0, 8'h22);
    $display("error cycle cs=0 rd=0 wr=0 ad_in=0x77");
    cs = 1'b0; a_d = 1'b1; rd = 1'b0; wr = 1'b0; ad_in = 8'h77;
    repeat (3) begin
      @(negedge clk);
      check("err_oe_low", ad_oe, 0);
    end
    idle();
    repeat (2) begin
      @(negedge clk);
      check("err_oe_after", ad_oe, 0);
    end
    read_reg(8'h22, 8'h12, "err_min_kept");

`ifdef RTC_TIMER_EN
    wait_phase(1);
    write_reg(8'h41, 8'h02);
    write_reg(8'h42, 8'h00);
    write_reg(8'h43, 8'h00);
    write_reg(8'h00, 8'h08);
    wait_phase(1);
    check("tmr_alarma_t1", alarma, 1);
    read_reg(8'h41, 8'h01, "tmr_seg_t1");
    wait_phase(1);
    check("tmr_alarma_t2", alarma, 1);
    read_reg(8'h41, 8'h00, "tmr_seg_t2");
    wait_phase(TD - 1);
    check("tmr_alarma_pre_t3", alarma, 1);
    wait_phase(1);
    check("tmr_alarma_t3", alarma, 0);
    read_reg(8'h00, 8'h01, "tmr_ctrl_expired");
    write_reg(8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("tmr_alarma_clear", alarma, 1);
    read_reg(8'h00, 8'h00, "tmr_ctrl_clear");
    wait_phase(1);
    write_reg(8'h43, 8'h01);
    write_reg(8'h42, 8'h00);
    write_reg(8'h41, 8'h00);
    write_reg(8'h00, 8'h08);
    wait_phase(1);
    read_reg(8'h43, 8'h00, "tmr_borrow_hora");
    read_reg(8'h42, 8'h59, "tmr_borrow_min");
    read_reg(8'h41, 8'h59, "tmr_borrow_seg");
    read_reg(8'h00, 8'h08, "tmr_ctrl_run");
    write_reg(8'h00, 8'h00);
`else
    wait_phase(1);
    write_reg(8'h41, 8'h05);
    write_reg(8'h00, 8'h09);
    read_reg(8'h41, 8'h00, "notmr_seg_t");
    read_reg(8'h00, 8'h00, "notmr_ctrl");
    repeat (3) wait_phase(1);
    check("notmr_alarma", alarma, 1);
`endif

    // Reset asserted after the data-phase strobe but before the commit.
    wait_phase(1);
    write_reg(8'h23, 8'h05);
    write_reg(8'h24, 8'h15);
    read_reg(8'h24, 8'h15, "pre_rst_dia");
    phase_write(1'b0, 8'h21);
    $display("write addr=0x21 data=0x55 (interrupted by reset)");
    cs = 1'b0; a_d = 1'b1; ad_in = 8'h55; wr = 1'b0; rd = 1'b1;
    @(negedge clk);
    wr = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    check("midrst_ad_oe", ad_oe, 0);
    check("midrst_ad_out", ad_out, 8'h00);
    check("midrst_alarma", alarma, 1);
    reset = 1'b0;
    check_cal("midrst", 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    read_reg(8'h00, 8'h00, "midrst_ctrl");

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per one-second tick.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cs  input  1  chip select, active low.
REQ-005 SHALL have port a_d  input  1  bus phase: 0 = address, 1 = data.
REQ-006 SHALL have port wr  input  1  write strobe, active low.
REQ-007 SHALL have port rd  input  1  read strobe, active low.
REQ-008 SHALL have port ad_in  input  8  multiplexed address/data from the initiator.
REQ-009 SHALL have port ad_out  output  8  read data driven to the bus.
REQ-010 SHALL have port ad_oe  output  1  bus drive enable for ad_out, active high.
REQ-011 SHALL have port alarma  output  1  timer-expired flag, active low.

Function
REQ-012 SHALL register cs/a_d/wr/rd each cycle and detect wr and rd edges against the previous sample.
REQ-013 SHALL, on a wr rising edge with cs=0 and a_d=0 in the previous sample, latch the ad_in value held in that sample as the current address.
REQ-014 SHALL, on a wr rising edge with cs=0 and a_d=1, write that sample's ad_in to the addressed register one cycle after the edge is detected.
REQ-015 SHALL implement the map 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio, 0x41 seg_t, 0x42 min_t, 0x43 hora_t, 0x00 control (bit3 run, bit0 expired, read-only).
REQ-016 SHALL return 0x00 on reads of unmapped addresses and ignore writes to them.
REQ-017 SHALL, on the first sample with cs=0, a_d=1, rd=0, wr=1, snapshot the addressed register into ad_out and assert ad_oe the next cycle.
REQ-018 SHALL hold ad_out stable while the read persists and deassert ad_oe the cycle after cs or rd samples high.
REQ-019 SHALL treat cs=0 with rd=0 and wr=0 together as a protocol error: no write, no read, ad_oe=0.
REQ-020 SHALL generate a one-cycle tick every TICK_DIV cycles from a free-running prescaler.
REQ-021 SHALL advance the clock in packed BCD on each tick: seg 00-59, min 00-59, hora 00-23, dia 01 to days-of-month, mes 01-12, anio 00-99; each wrap carries to the next field.
REQ-022 SHALL use February 29 days when anio (BCD) is divisible by 4, else 28; 30 days for months 04/06/09/11.
REQ-023 SHALL, on tick, reset any field whose value is >= its maximum (including non-BCD values) to its minimum with carry.
REQ-024 SHALL, when a register write coincides with a tick, commit the write and defer the tick by exactly one cycle.
REQ-025 SHALL, when run=1, decrement the timer hora_t:min_t:seg_t in BCD by one second per tick.
REQ-026 SHALL, when the timer is 00:00:00 at a tick with run=1, set expired, clear run, and drive alarma=0.
REQ-027 SHALL clear expired and release alarma (1) on any write to address 0x00, then apply bit3 of the data to run.

Reset
REQ-028 SHALL, on reset, set seg/min/hora/anio/timer/control/address/prescaler to 0x00, dia and mes to 0x01, ad_out=0x00, ad_oe=0, alarma=1.
REQ-029 SHALL discard any in-flight transaction when reset asserts mid-access; no partial write is committed.

Configuration
REQ-030 SHALL, with macro RTC_TIMER_EN defined, implement REQ-025 to REQ-027 and timer addresses 0x41-0x43.
REQ-031 SHALL, without RTC_TIMER_EN, read 0x41-0x43 and control bits 3/0 as 0, ignore their writes, and hold alarma=1.

Verification
REQ-032 SHALL cover: write addr 0x21 then data 0x45, read 0x21 -> ad_out=0x45, ad_oe high only while rd low.
REQ-033 SHALL cover: set 23:59:59 on 28/02/23, one tick -> 00:00:00 01/03/23; same with anio=0x24 -> 29/02/24.
REQ-034 SHALL cover: TICK_DIV=4, timer 00:00:02, write 0x08 to 0x00 -> alarma=0 on third tick, control reads 0x01; write 0x00 -> alarma=1.
REQ-035 SHALL cover: data write to 0x21 in the tick cycle -> written value stored, increment lands one cycle later.
REQ-036 SHALL cover: cs=0, rd=0, wr=0 -> ad_oe stays 0, registers unchanged; reset during data phase -> all reset values.
